// File: rtl/pe_axil_cmd_engine.sv
// Single-outstanding command sequencer: turns one flat rd/wr command into an
// AXI4-Lite AR/R or AW/W/B exchange and returns one response, with a timeout.
module pe_axil_cmd_engine #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  stray_rsp,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RSP, S_RD_REQ, S_RD_RSP, S_RSP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_timeout_q, rsp_timeout_d, stray_q, stray_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                bready_q, bready_d, rready_q, rready_d;
    logic                waiting, to_hit, abort;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        stray_d       = stray_q;

        waiting = (state_q == S_WR_REQ) || (state_q == S_WR_RSP) ||
                  (state_q == S_RD_REQ) || (state_q == S_RD_RSP);
        to_hit  = (TIMEOUT != 0) && waiting && (cnt_q == CNT_W'(TIMEOUT - 1));
        if (waiting) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready_q) begin
                addr_d    = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                cnt_d     = '0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = cmd_write ? S_WR_REQ : S_RD_REQ;
            end
            S_WR_REQ: begin
                aw_done_d = aw_done_q | (awvalid_q & m_awready);
                w_done_d  = w_done_q | (wvalid_q & m_wready);
                if (aw_done_d && w_done_d) state_d = S_WR_RSP;
            end
            S_WR_RSP: if (m_bvalid && bready_q) begin
                rsp_rdata_d   = '0;
                rsp_resp_d    = m_bresp;
                rsp_timeout_d = 1'b0;
                state_d       = S_RSP;
            end
            S_RD_REQ: if (arvalid_q && m_arready) state_d = S_RD_RSP;
            S_RD_RSP: if (m_rvalid && rready_q) begin
                rsp_rdata_d   = m_rdata;
                rsp_resp_d    = m_rresp;
                rsp_timeout_d = 1'b0;
                state_d       = S_RSP;
            end
            S_RSP: if (rsp_ready && rsp_valid_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A response beat landing on the timeout cycle already moved us to RSP and wins.
        abort = to_hit && (state_d != S_RSP);
        if (abort) begin
            state_d       = S_RSP;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
        end

        if ((state_q == S_IDLE || state_q == S_RSP) && (m_bvalid || m_rvalid)) stray_d = 1'b1;

        // Outputs are registered from the next state so valids never see readies combinationally.
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);
        awvalid_d   = (state_d == S_WR_REQ) && !aw_done_d;
        wvalid_d    = (state_d == S_WR_REQ) && !w_done_d;
        arvalid_d   = (state_d == S_RD_REQ);
        bready_d    = (state_d == S_IDLE) || (state_d == S_WR_RSP) || (state_d == S_RSP);
        rready_d    = (state_d == S_IDLE) || (state_d == S_RD_RSP) || (state_d == S_RSP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            stray_q       <= stray_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign stray_rsp   = stray_q;
    assign m_awaddr    = addr_q;
    assign m_awvalid   = awvalid_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign m_wvalid    = wvalid_q;
    assign m_bready    = bready_q;
    assign m_araddr    = addr_q;
    assign m_arvalid   = arvalid_q;
    assign m_rready    = rready_q;
endmodule

// File: tb/tb_pe_axil_cmd_engine.sv
// Bench for pe_axil_cmd_engine: table of commands against a delay-configurable
// AXI-Lite slave, scoreboarded responses, plus timeout/stray/reset/back-to-back sequences.
module tb_pe_axil_cmd_engine;
    localparam int TO = 16;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, stray_rsp;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
    logic        s_rvalid, h_rvalid;

    assign m_rvalid = s_rvalid | h_rvalid;

    pe_axil_cmd_engine #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .stray_rsp(stray_rsp),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave knobs: a ready rises after <wait> cycles of valid (-1 = never);
    // a response beat appears <rsp_wait> cycles after the request completes.
    int          ar_wait, aw_wait, w_wait, rsp_wait;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    int          ar_c, aw_c, w_c, r_c, b_c;
    logic        ar_hs, aw_hs, w_hs, r_hs, b_hs, r_pend, b_pend, aw_got, w_got;

    always @(negedge clk) begin
        if (rst) begin
            {ar_hs, aw_hs, w_hs, r_hs, b_hs, r_pend, b_pend, aw_got, w_got} = '0;
            {m_arready, m_awready, m_wready, s_rvalid, m_bvalid} = '0;
            ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
        end else begin
            if (ar_hs) begin r_pend = 1'b1; r_c = 0; end
            if (r_hs) r_pend = 1'b0;
            if (aw_hs) aw_got = 1'b1;
            if (w_hs) w_got = 1'b1;
            if (b_hs) b_pend = 1'b0;
            if (aw_got && w_got && !b_pend) begin b_pend = 1'b1; b_c = 0; aw_got = 1'b0; w_got = 1'b0; end
            ar_c = m_arvalid ? ar_c + 1 : 0;
            aw_c = m_awvalid ? aw_c + 1 : 0;
            w_c  = m_wvalid ? w_c + 1 : 0;
            m_arready = m_arvalid && ar_wait >= 0 && ar_c > ar_wait;
            m_awready = m_awvalid && aw_wait >= 0 && aw_c > aw_wait;
            m_wready  = m_wvalid && w_wait >= 0 && w_c > w_wait;
            s_rvalid  = r_pend && r_c >= rsp_wait;
            m_bvalid  = b_pend && b_c >= rsp_wait;
            if (r_pend) r_c++;
            if (b_pend) b_c++;
            ar_hs = m_arvalid && m_arready;
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            r_hs  = s_rvalid && m_rready;
            b_hs  = m_bvalid && m_bready;
        end
        m_rdata = s_rdata;
        m_rresp = s_resp;
        m_bresp = s_resp;
    end

    typedef struct {
        logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
        int arw; int aww; int ww; int rw; logic [1:0] sresp; logic [31:0] srdata; int hold;
        logic [31:0] e_rdata; logic [1:0] e_resp; logic e_to; int e_lat;
    } vec_t;
    typedef struct { logic [31:0] rdata; logic [1:0] resp; logic to; int lat; } exp_t;

    vec_t tbl[8];
    exp_t sb[$];
    int   checks, errors;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns at a negedge with it idle again.
    task automatic do_cmd(input vec_t v);
        exp_t e;
        int   cyc;
        logic got;
        ar_wait = v.arw; aw_wait = v.aww; w_wait = v.ww; rsp_wait = v.rw;
        s_resp = v.sresp; s_rdata = v.srdata;
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        cmd_valid = 1'b1;
        rsp_ready = (v.hold == 0);
        sb.push_back('{v.e_rdata, v.e_resp, v.e_to, v.e_lat});
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        got = 1'b0;
        for (cyc = 1; cyc <= 60 && !got; cyc++) begin
            @(negedge clk);
            if (!v.wr) begin
                chk("arvalid", m_arvalid, (v.arw < 0) ? (cyc <= TO) : (cyc <= v.arw + 1));
                if (cyc == 1) chk("araddr", m_araddr, v.addr);
            end else begin
                chk("awvalid", m_awvalid, cyc <= v.aww + 1);
                chk("wvalid", m_wvalid, cyc <= v.ww + 1);
                if (cyc == 1) chk("aw_payload", {m_awaddr, m_wdata}, {v.addr, v.wdata});
                if (cyc == 1) chk("wstrb", m_wstrb, v.strb);
            end
            if (rsp_valid) begin
                got = 1'b1;
                e = sb.pop_front();
                chk("rsp_latency", cyc, e.lat);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", rsp_resp, e.resp);
                chk("rsp_timeout", rsp_timeout, e.to);
                chk("cmd_ready_busy", cmd_ready, 0);
            end
        end
        if (!got) begin
            chk("rsp_arrived", 0, 1);
            void'(sb.pop_front());
        end
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {rsp_valid, rsp_resp, cmd_ready}, {1'b1, e.resp, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rsp", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        int n_ar, n_rsp;
        logic prev;
        checks = 0; errors = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b1; h_rvalid = 1'b0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; rsp_wait = 0; s_resp = 0; s_rdata = 0;

        //          wr    addr      wdata         strb arw aww ww rw  sresp  srdata        hold e_rdata       e_resp e_to lat
        tbl[0] = '{1'b0, 32'h40, 32'h0,        4'h0, 0,  0,  0, 0,  2'b00, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'b00, 1'b0, 3};
        tbl[1] = '{1'b1, 32'h80, 32'h12345678, 4'hF, 0,  0,  3, 0,  2'b00, 32'h0,        0, 32'h0,        2'b00, 1'b0, 6};
        tbl[2] = '{1'b1, 32'h84, 32'hA5A5A5A5, 4'h3, 0,  0,  0, 0,  2'b10, 32'h0,        5, 32'h0,        2'b10, 1'b0, 3};
        tbl[3] = '{1'b0, 32'h44, 32'h0,        4'h0, 2,  0,  0, 1,  2'b01, 32'h0BADF00D, 0, 32'h0BADF00D, 2'b01, 1'b0, 6};
        tbl[4] = '{1'b1, 32'h88, 32'hCAFEF00D, 4'hC, 0,  2,  0, 2,  2'b11, 32'h0,        0, 32'h0,        2'b11, 1'b0, 7};
        tbl[5] = '{1'b0, 32'h48, 32'h0,        4'h0, 0,  0,  0, 14, 2'b00, 32'h000055AA, 0, 32'h000055AA, 2'b00, 1'b0, 17};
        tbl[6] = '{1'b0, 32'h4C, 32'h0,        4'h0, -1, 0,  0, 0,  2'b00, 32'hFFFFFFFF, 0, 32'h0,        2'b10, 1'b1, 17};
        tbl[7] = '{1'b0, 32'h50, 32'h0,        4'h0, 0,  0,  0, 0,  2'b00, 32'h600DCAFE, 0, 32'h600DCAFE, 2'b00, 1'b0, 3};

        // Reset state and the first cycle after release.
        @(negedge clk);
        chk("rst_ctl", {cmd_ready, rsp_valid, rsp_timeout, stray_rsp, m_awvalid, m_wvalid,
                        m_arvalid, m_bready, m_rready, rsp_resp}, 0);
        chk("rst_data", {rsp_rdata, m_wdata}, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("cmd_ready_pre_edge", cmd_ready, 0);
        @(negedge clk);
        chk("idle_readies", {cmd_ready, m_bready, m_rready}, 3'b111);

        for (int i = 0; i < 7; i++) do_cmd(tbl[i]);

        // Late R beat after the timeout is sunk and flagged sticky.
        chk("stray_before", stray_rsp, 0);
        h_rvalid = 1'b1;
        @(posedge clk); #1 h_rvalid = 1'b0;
        @(negedge clk); chk("stray_set", stray_rsp, 1);
        @(negedge clk); chk("stray_sticky", stray_rsp, 1);

        // Reset while waiting in WR_RSP aborts with no response.
        ar_wait = 0; aw_wait = 0; w_wait = 0; rsp_wait = 100;
        cmd_write = 1'b1; cmd_addr = 32'h90; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("in_wr_rsp", {m_bready, m_awvalid, m_wvalid, rsp_valid}, 4'b1000);
        rst = 1'b1;
        #1 chk("midrst_ctl", {cmd_ready, rsp_valid, rsp_timeout, stray_rsp, m_awvalid, m_wvalid,
                              m_arvalid, m_bready, m_rready, rsp_resp}, 0);
        @(negedge clk); chk("midrst_norsp", rsp_valid, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); chk("after_rst", {cmd_ready, rsp_valid}, 2'b10);
        do_cmd(tbl[7]);

        // Back-to-back reads with cmd_valid held high.
        ar_wait = 0; rsp_wait = 0; s_rdata = 32'h1234ABCD; s_resp = 0;
        cmd_write = 1'b0; cmd_addr = 32'h100; cmd_valid = 1'b1; rsp_ready = 1'b1;
        n_ar = 0; n_rsp = 0; prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (m_arvalid) n_ar++;
            if (prev) chk("b2b_cmd_ready", cmd_ready, 1);
            prev = rsp_valid;
            if (rsp_valid) begin
                n_rsp++;
                chk("b2b_rdata", rsp_rdata, 32'h1234ABCD);
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk); chk("b2b_end", {cmd_ready, rsp_valid}, 2'b10);
        chk("b2b_rsp_count", n_rsp, 5);
        chk("b2b_ar_per_cmd", n_ar, n_rsp);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
